// File: rtl/muldiv_sequencer.sv
// ============================================================================
// muldiv_sequencer: runs multu/divu as WIDTH single-ALU-op iterations into HI/LO
// Revision: 1.0
// ============================================================================
`default_nettype none

module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result
);

  localparam int             CNT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
  localparam logic [2:0]     CTRL_ADD  = 3'b010;
  localparam logic [2:0]     CTRL_SUB  = 3'b110;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t           state, state_next;
  // opnd holds M (multu) or D (divu); acc is P_hi or R; shq is P_lo or Q
  logic [WIDTH-1:0] opnd, acc, shq;
  logic [CNT_W-1:0] cnt;
  logic             zero_div;
  logic [WIDTH-1:0] rem_shift;
  logic             carry, ge;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    alu_a      = '0;
    alu_b      = '0;
    rem_shift  = {acc[WIDTH-2:0], shq[WIDTH-1]};
    // The ALU has no carry/borrow out, so recover them by unsigned compares
    carry      = (alu_result < acc);
    ge         = acc[WIDTH-1] | (rem_shift >= opnd);
    case (state)
      IDLE: begin
        if (start) begin
          if (!op)              state_next = MUL;
          else if (rt_val == '0) state_next = FIN;
          else                  state_next = DIV;
        end
      end
      MUL: begin
        alu_a = acc;
        alu_b = shq[0] ? opnd : '0;
        if (cnt == LAST_ITER) state_next = FIN;
      end
      DIV: begin
        alu_a = rem_shift;
        alu_b = opnd;
        if (cnt == LAST_ITER) state_next = FIN;
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      alu_ctrl    <= CTRL_ADD;
      opnd        <= '0;
      acc         <= '0;
      shq         <= '0;
      cnt         <= '0;
      zero_div    <= 1'b0;
    end else begin
      done     <= 1'b0;
      alu_ctrl <= (state_next == DIV) ? CTRL_SUB : CTRL_ADD;
      case (state)
        IDLE: begin
          if (start) begin
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            acc         <= '0;
            zero_div    <= op && (rt_val == '0);
            opnd        <= op ? rt_val : rs_val;
            shq         <= op ? rs_val : rt_val;
          end
        end
        MUL: begin
          acc <= {carry, alu_result[WIDTH-1:1]};
          shq <= {alu_result[0], shq[WIDTH-1:1]};
          cnt <= cnt + CNT_W'(1);
        end
        DIV: begin
          acc <= ge ? alu_result : rem_shift;
          shq <= {shq[WIDTH-2:0], ge};
          cnt <= cnt + CNT_W'(1);
        end
        FIN: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (zero_div) begin
            hi          <= shq;
            lo          <= '1;
            div_by_zero <= 1'b1;
          end else begin
            hi <= acc;
            lo <= shq;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
// ============================================================================
// tb_muldiv_sequencer: scoreboard bench for muldiv_sequencer with an ALU model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, op;
  logic [W-1:0] rs_val, rt_val, hi, lo, alu_a, alu_b, alu_result;
  logic         busy, done, div_by_zero;
  logic [2:0]   alu_ctrl;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result)
  );

  always #5 clk = ~clk;

  // Combinational EX-stage ALU
  assign alu_result = (alu_ctrl == 3'b110) ? (alu_a - alu_b) : (alu_a + alu_b);

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           lat;
    int           start_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    logic [63:0] p;
    e.start_cyc = 0;
    e.dbz = 1'b0;
    e.lat = W + 1;
    if (!o) begin
      p    = 64'(a) * 64'(b);
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == '0) begin
      e.hi  = a;
      e.lo  = '1;
      e.dbz = 1'b1;
      e.lat = 1;
    end else begin
      e.lo = a / b;
      e.hi = a % b;
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got a done pulse, required none (no operation pending)");
      end else begin
        mon_e = sb.pop_front();
        check("result_hi", 64'(hi), 64'(mon_e.hi));
        check("result_lo", 64'(lo), 64'(mon_e.lo));
        check("result_dbz", 64'(div_by_zero), 64'(mon_e.dbz));
        check("latency", 64'(cyc - mon_e.start_cyc), 64'(mon_e.lat));
      end
    end
  end

  // Called at posedge+2; start is sampled at the next edge
  task automatic issue(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e = model(o, a, b);
    e.start_cyc = cyc + 1;
    sb.push_back(e);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    @(posedge clk); #2;
    start  = 1'b0;
    op     = 1'($urandom);
    rs_val = $urandom;
    rt_val = $urandom;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s: timeout with %0d results pending, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic pulse_ignored_start();
    start  = 1'b1;
    op     = 1'($urandom);
    rs_val = $urandom;
    rt_val = $urandom;
    @(posedge clk); #2;
    start  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt, bad_ctrl, k;
    logic o;
    logic [W-1:0] a, b;

    reset = 1'b1; start = 1'b0; op = 1'b0; rs_val = '0; rt_val = '0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_alu_ctrl", 64'(alu_ctrl), 64'(3'b010));
    reset = 1'b0;
    @(posedge clk); #2;

    // multu 7 x 6: busy span and ALU control while busy
    issue(1'b0, 32'd7, 32'd6);
    busy_cnt = 0;
    bad_ctrl = 0;
    repeat (40) begin
      if (busy) begin
        busy_cnt++;
        if (alu_ctrl !== 3'b010) bad_ctrl++;
      end
      @(posedge clk); #2;
    end
    check("mul_busy_cycles", 64'(busy_cnt), 64'd33);
    check("mul_alu_ctrl_bad", 64'(bad_ctrl), 64'd0);
    wait_done("mul_7x6");

    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("mul_max");
    issue(1'b1, 32'd100, 32'd7);
    wait_done("div_100_7");
    issue(1'b1, 32'hFFFF_FFFF, 32'h8000_0001);
    repeat (3) @(posedge clk);
    #2;
    check("div_alu_ctrl", 64'(alu_ctrl), 64'(3'b110));
    wait_done("div_ov");

    // divide by zero, then hold, then cleared by the next start
    issue(1'b1, 32'h0000_1234, 32'd0);
    wait_done("div_zero");
    repeat (5) @(posedge clk);
    #2;
    check("hold_hi", 64'(hi), 64'h1234);
    check("hold_lo", 64'(lo), 64'hFFFF_FFFF);
    check("hold_dbz", 64'(div_by_zero), 64'd1);
    issue(1'b0, 32'd2, 32'd3);
    check("dbz_cleared", 64'(div_by_zero), 64'd0);
    wait_done("mul_2x3");

    // starts while busy and in the final cycle are ignored
    issue(1'b0, $urandom, $urandom);
    repeat (5) @(posedge clk);
    #2;
    pulse_ignored_start();
    repeat (26) @(posedge clk);
    #2;
    pulse_ignored_start();
    wait_done("ignored_starts");

    // back-to-back: start right after the done cycle
    issue(1'b1, $urandom, 32'h0001_0003);
    wait_done("b2b_div");
    issue(1'b0, 32'h89AB_CDEF, 32'h0001_2345);
    wait_done("b2b_mul");

    // asynchronous reset in the middle of a multu
    issue(1'b0, 32'hDEAD_BEEF, 32'h0001_2345);
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_lo", 64'(lo), 64'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #2;
    issue(1'b0, 32'd2, 32'd3);
    wait_done("after_reset");

    // randomized mix
    for (int i = 0; i < 16; i++) begin
      o = 1'($urandom);
      a = $urandom;
      k = $urandom_range(0, 3);
      case (k)
        0:       b = '0;
        1:       b = W'($urandom_range(1, 255));
        2:       b = $urandom;
        default: b = 32'h8000_0000 | $urandom;
      endcase
      issue(o, a, b);
      wait_done("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
